// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: connects the EX/MEM register and the memory stage to the
// MEM/WB stage, and carries the register-file write port, halt flag and
// retired count back out.
//   master : EX/MEM side; drives i_* fields, observes o_* results
//   slave  : mem_wb_stage; consumes i_* fields, drives o_* results
interface mem_wb_stage_if #(
    parameter int unsigned NB_WIDTH = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_CNT   = 32
);
    // Pipeline advance and EX/MEM fields
    logic                i_enable;
    logic                i_valid;
    logic                i_reg_write;
    logic [1:0]          i_wb_sel;
    logic [NB_REG-1:0]   i_rd_addr;
    logic [NB_WIDTH-1:0] i_alu_result;
    logic [NB_WIDTH-1:0] i_pc_plus8;
    logic                i_halt;
    // Load data, already registered and extended by the memory stage
    logic [NB_WIDTH-1:0] i_mem_read_data;

    // Register-file write port and debug status
    logic                o_wb_we;
    logic [NB_REG-1:0]   o_wb_addr;
    logic [NB_WIDTH-1:0] o_wb_data;
    logic                o_halted;
    logic [NB_CNT-1:0]   o_retired;

    modport master (
        output i_enable, i_valid, i_reg_write, i_wb_sel, i_rd_addr,
               i_alu_result, i_pc_plus8, i_halt, i_mem_read_data,
        input  o_wb_we, o_wb_addr, o_wb_data, o_halted, o_retired
    );

    modport slave (
        input  i_enable, i_valid, i_reg_write, i_wb_sel, i_rd_addr,
               i_alu_result, i_pc_plus8, i_halt, i_mem_read_data,
        output o_wb_we, o_wb_addr, o_wb_data, o_halted, o_retired
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back data selection and
// halt/retire tracking for the MIPS core.
//   i_clk    : clock
//   i_reset  : synchronous, active-high reset
//   bus      : mem_wb_stage_if.slave
//              in  : i_enable, i_valid, i_reg_write, i_wb_sel, i_rd_addr,
//                    i_alu_result, i_pc_plus8, i_halt, i_mem_read_data
//              out : o_wb_we, o_wb_addr, o_wb_data (combinational from the
//                    MEM/WB register), o_halted, o_retired
// A HALT reaching write-back freezes the stage until reset.
module mem_wb_stage #(
    parameter int unsigned NB_WIDTH = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_CNT   = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mem_wb_stage_if.slave   bus
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    // Fields captured from EX/MEM
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic [1:0]          wb_sel;
        logic [NB_REG-1:0]   rd;
        logic [NB_WIDTH-1:0] alu;
        logic [NB_WIDTH-1:0] pc8;
        logic                halt;
    } wb_fields_t;

    wb_fields_t          fields_q;
    wb_fields_t          fields_d;
    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [NB_CNT-1:0]   retired_q;
    logic [NB_CNT-1:0]   retired_d;

    logic                advance;
    logic                halt_commit;
    logic                capture;
    logic                retire;
    logic                wb_we;
    logic [NB_WIDTH-1:0] wb_data;

    // State, captured fields and retire counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= RUN;
            fields_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fields_q  <= fields_d;
            retired_q <= retired_d;
        end
    end

    // Next state, capture, counting and write-back selection
    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        retired_d   = retired_q;
        advance     = 1'b0;
        halt_commit = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        wb_we       = 1'b0;
        wb_data     = fields_q.alu;

        advance     = bus.i_enable & (state_q == RUN);
        // The HALT in write-back blocks the instruction behind it from entering.
        halt_commit = advance & fields_q.valid & fields_q.halt;
        capture     = advance & ~halt_commit;
        retire      = advance & fields_q.valid & ~fields_q.halt;

        case (state_q)
            RUN:     if (halt_commit) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        if (capture) begin
            fields_d.valid     = bus.i_valid;
            fields_d.reg_write = bus.i_reg_write;
            fields_d.wb_sel    = bus.i_wb_sel;
            fields_d.rd        = bus.i_rd_addr;
            fields_d.alu       = bus.i_alu_result;
            fields_d.pc8       = bus.i_pc_plus8;
            fields_d.halt      = bus.i_halt;
        end

        // Counts stores and $zero writes too; wraps naturally.
        if (retire) begin
            retired_d = retired_q + NB_CNT'(1);
        end

        // Load data arrives registered at the same edge as the fields.
        case (fields_q.wb_sel)
            SEL_MEM:  wb_data = bus.i_mem_read_data;
            SEL_LINK: wb_data = fields_q.pc8;
            default:  wb_data = fields_q.alu;
        endcase

        wb_we = retire & fields_q.reg_write & (fields_q.rd != '0);
    end

    assign bus.o_wb_we   = wb_we;
    assign bus.o_wb_addr = fields_q.rd;
    assign bus.o_wb_data = wb_data;
    assign bus.o_halted  = (state_q == HALTED);
    assign bus.o_retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage (counter width 4 so the
// wrap case is reachable).
module tb_mem_wb_stage;

    localparam int unsigned NB_WIDTH = 32;
    localparam int unsigned NB_REG   = 5;
    localparam int unsigned NB_CNT   = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_wb_stage_if #(.NB_WIDTH(NB_WIDTH), .NB_REG(NB_REG), .NB_CNT(NB_CNT)) bus ();

    mem_wb_stage #(.NB_WIDTH(NB_WIDTH), .NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an EX/MEM slot plus the memory stage's data for it
    task automatic set_slot(input logic v, input logic rw, input logic [1:0] sel,
                            input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] pc8, input logic hlt,
                            input logic [31:0] mem);
        bus.i_valid         = v;
        bus.i_reg_write     = rw;
        bus.i_wb_sel        = sel;
        bus.i_rd_addr       = rd;
        bus.i_alu_result    = alu;
        bus.i_pc_plus8      = pc8;
        bus.i_halt          = hlt;
        bus.i_mem_read_data = mem;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_enable = 1'b1;
        set_slot(1'b1, 1'b1, 2'b00, 5'd7, 32'hAAAA_5555, 32'h100, 1'b0, 32'h1);
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b want=0", bus.o_wb_we); end
        n_checks++; if (bus.o_wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", bus.o_wb_addr); end
        n_checks++; if (bus.o_wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h want=0", bus.o_wb_data); end
        n_checks++; if (bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%0b want=0", bus.o_halted); end
        n_checks++; if (bus.o_retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired got=%0d want=0", bus.o_retired); end
        rst = 1'b0;
    endtask

    task automatic test_alu_write();
        set_slot(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234, 32'h8, 1'b0, 32'hBAD0);
        tick();
        n_checks++; if (bus.o_wb_we !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%0b want=1", bus.o_wb_we); end
        n_checks++; if (bus.o_wb_addr !== 5'd5) begin n_fail++; $display("FAIL alu_addr got=%0d want=5", bus.o_wb_addr); end
        n_checks++; if (bus.o_wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_data got=%h want=1234", bus.o_wb_data); end
        n_checks++; if (bus.o_retired !== 4'd0) begin n_fail++; $display("FAIL alu_retired_pre got=%0d want=0", bus.o_retired); end
        set_slot(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.o_retired !== 4'd1) begin n_fail++; $display("FAIL alu_retired_post got=%0d want=1", bus.o_retired); end
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL alu_bubble_we got=%0b want=0", bus.o_wb_we); end
    endtask

    task automatic test_load_link();
        set_slot(1'b1, 1'b1, 2'b01, 5'd8, 32'hDEAD, 32'h44, 1'b0, 32'hFFFF_FF80);
        tick();
        n_checks++; if (bus.o_wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL load_data got=%h want=ffffff80", bus.o_wb_data); end
        n_checks++; if (bus.o_wb_we !== 1'b1 || bus.o_wb_addr !== 5'd8) begin n_fail++; $display("FAIL load_port got=we%0b/a%0d want=we1/a8", bus.o_wb_we, bus.o_wb_addr); end
        set_slot(1'b1, 1'b1, 2'b10, 5'd31, 32'h55, 32'h40, 1'b0, 32'h77);
        tick();
        n_checks++; if (bus.o_wb_data !== 32'h40) begin n_fail++; $display("FAIL link_data got=%h want=40", bus.o_wb_data); end
        n_checks++; if (bus.o_wb_addr !== 5'd31) begin n_fail++; $display("FAIL link_addr got=%0d want=31", bus.o_wb_addr); end
        n_checks++; if (bus.o_retired !== 4'd2) begin n_fail++; $display("FAIL link_retired got=%0d want=2", bus.o_retired); end
        set_slot(1'b1, 1'b1, 2'b11, 5'd2, 32'hABC, 32'h99, 1'b0, 32'h77);
        tick();
        n_checks++; if (bus.o_wb_data !== 32'hABC) begin n_fail++; $display("FAIL sel11_data got=%h want=abc", bus.o_wb_data); end
        n_checks++; if (bus.o_retired !== 4'd3) begin n_fail++; $display("FAIL sel11_retired got=%0d want=3", bus.o_retired); end
    endtask

    task automatic test_zero_bubble();
        set_slot(1'b1, 1'b1, 2'b00, 5'd0, 32'h1, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL zero_we got=%0b want=0", bus.o_wb_we); end
        n_checks++; if (bus.o_retired !== 4'd4) begin n_fail++; $display("FAIL zero_retired_pre got=%0d want=4", bus.o_retired); end
        set_slot(1'b0, 1'b1, 2'b00, 5'd4, 32'h9, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL bubble_we got=%0b want=0", bus.o_wb_we); end
        n_checks++; if (bus.o_retired !== 4'd5) begin n_fail++; $display("FAIL zero_counted got=%0d want=5", bus.o_retired); end
        tick();
        n_checks++; if (bus.o_retired !== 4'd5) begin n_fail++; $display("FAIL bubble_not_counted got=%0d want=5", bus.o_retired); end
    endtask

    task automatic test_stall();
        set_slot(1'b1, 1'b1, 2'b00, 5'd3, 32'h7, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.o_wb_we !== 1'b1 || bus.o_wb_data !== 32'h7) begin n_fail++; $display("FAIL stall_capture got=we%0b/d%h want=we1/d7", bus.o_wb_we, bus.o_wb_data); end
        bus.i_enable = 1'b0;
        set_slot(1'b1, 1'b1, 2'b00, 5'd6, 32'h66, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL stall_we cyc%0d got=%0b want=0", i, bus.o_wb_we); end
            tick();
            n_checks++; if (bus.o_retired !== 4'd5 || bus.o_wb_addr !== 5'd3) begin n_fail++; $display("FAIL stall_hold cyc%0d got=r%0d/a%0d want=r5/a3", i, bus.o_retired, bus.o_wb_addr); end
        end
        bus.i_enable = 1'b1;
        set_slot(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++; if (bus.o_wb_we !== 1'b1 || bus.o_wb_data !== 32'h7 || bus.o_wb_addr !== 5'd3) begin n_fail++; $display("FAIL stall_release got=we%0b/a%0d/d%h want=we1/a3/d7", bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data); end
        tick();
        n_checks++; if (bus.o_retired !== 4'd6) begin n_fail++; $display("FAIL stall_once got=%0d want=6", bus.o_retired); end
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL stall_after_we got=%0b want=0", bus.o_wb_we); end
    endtask

    task automatic test_halt();
        set_slot(1'b1, 1'b1, 2'b00, 5'd10, 32'h10, 32'h0, 1'b1, 32'h0);
        tick();
        n_checks++; if (bus.o_wb_we !== 1'b0 || bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL halt_wb got=we%0b/h%0b want=we0/h0", bus.o_wb_we, bus.o_halted); end
        set_slot(1'b1, 1'b1, 2'b00, 5'd9, 32'h99, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.o_halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got=%0b want=1", bus.o_halted); end
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL halt_we got=%0b want=0", bus.o_wb_we); end
        tick();
        n_checks++; if (bus.o_wb_addr !== 5'd10 || bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL halt_r9_blocked got=a%0d/we%0b want=a10/we0", bus.o_wb_addr, bus.o_wb_we); end
        n_checks++; if (bus.o_retired !== 4'd6 || bus.o_halted !== 1'b1) begin n_fail++; $display("FAIL halt_frozen got=r%0d/h%0b want=r6/h1", bus.o_retired, bus.o_halted); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.o_halted !== 1'b0 || bus.o_retired !== 4'd0) begin n_fail++; $display("FAIL halt_reset got=h%0b/r%0d want=h0/r0", bus.o_halted, bus.o_retired); end
        n_checks++; if (bus.o_wb_we !== 1'b0) begin n_fail++; $display("FAIL halt_reset_we got=%0b want=0", bus.o_wb_we); end
    endtask

    task automatic test_wrap();
        set_slot(1'b1, 1'b0, 2'b00, 5'd1, 32'h5, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 17; i++) tick();
        // 17 captured, 16 committed
        n_checks++; if (bus.o_retired !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got=%0d want=0", bus.o_retired); end
        set_slot(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.o_retired !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got=%0d want=1", bus.o_retired); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.i_enable = 1'b0;
        set_slot(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_alu_write();
        test_load_link();
        test_zero_bubble();
        test_stall();
        test_halt();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Final pipeline stage of the MIPS core: the MEM/WB pipeline register plus write-back selection and halt/retire tracking. It captures the EX/MEM control and data fields on the same clock edge that the memory stage registers its load data. It then drives the register-file write port, the forwarding unit and the debug unit. A halt instruction reaching write-back freezes the stage until reset.

## Interface
Parameters:
- NB_WIDTH, 32, data/address width
- NB_REG, 5, register address width
- NB_CNT, 32, retired-instruction counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance (debug step/run); low = hold
- i_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- i_reg_write  in  1  instruction writes a GPR
- i_wb_sel  in  2  00 ALU result, 01 memory load data, 10 PC+8 (link), 11 ALU result
- i_rd_addr  in  NB_REG  destination register
- i_alu_result  in  NB_WIDTH  ALU result from EX/MEM
- i_pc_plus8  in  NB_WIDTH  link address
- i_halt  in  1  instruction is HALT
- i_mem_read_data  in  NB_WIDTH  memory-stage load data, already registered and extended by that stage
- o_wb_we  out  1  register-file write enable
- o_wb_addr  out  NB_REG  register-file write address
- o_wb_data  out  NB_WIDTH  register-file write data
- o_halted  out  1  sticky halt flag
- o_retired  out  NB_CNT  retired-instruction count

## Operation
- Capture register fields: valid_q, reg_write_q, wb_sel_q, rd_q, alu_q, pc8_q, halt_q.
- Capture occurs at a posedge when i_enable=1 and state=RUN. Otherwise all fields hold.
- Write-data mux is combinational from the registered fields:
  - wb_sel_q=01 selects i_mem_read_data.
  - wb_sel_q=10 selects pc8_q.
  - Any other value selects alu_q.
- o_wb_addr = rd_q.
- o_wb_we = valid_q & reg_write_q & ~halt_q & (rd_q != 0) & i_enable & (state == RUN).
  - Writes to $zero are always suppressed.
- State machine: RUN, HALTED.
  - RUN -> HALTED at a posedge with i_enable=1 and valid_q & halt_q.
  - HALTED is left only by i_reset. While HALTED: no capture, o_wb_we=0, counter frozen.
- o_halted = (state == HALTED).
- Counter increments at a posedge when i_enable & (state == RUN) & valid_q & ~halt_q.
  - It counts every retired non-halt instruction, including stores and rd=0 writes.
  - It wraps from 2^NB_CNT−1 to 0.
- HALT is not counted. Bubbles (valid_q=0) are not counted and never write.

## Timing
- Reset (posedge with i_reset=1) takes priority over i_enable:
  - All captured fields become 0; state becomes RUN; counter becomes 0.
  - Outputs after reset: o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_halted=0, o_retired=0.
- Latency: EX/MEM fields presented before edge t are captured at edge t. The memory stage registers the matching load data at the same edge t.
  - o_wb_data and o_wb_we are valid during cycle t+1.
  - The register file commits at edge t+1.
  - The counter updates at edge t+1.
- Load alignment: no extra delay is allowed on i_mem_read_data. It must pair with fields captured at the same edge.
- i_enable=0 during cycle t+1: o_wb_we=0 and there is no double count.
  - Fields hold. The upstream EX/MEM register is also frozen, so i_mem_read_data is stable.
  - When i_enable returns to 1, the held instruction commits exactly once.
- Halt at edge t+1 with a valid instruction in EX/MEM: that instruction is not captured, and it never writes.
- Reset asserted mid-HALTED or mid-stall: returns to RUN at that edge, no write issued in that cycle.

## Test plan
- Reset then ALU write: i_valid=1, reg_write=1, wb_sel=00, rd=5, alu=0x1234 at edge t.
  - Cycle t+1 shows o_wb_we=1, addr=5, data=0x1234.
  - o_retired=1 after edge t+1.
- Load path and link path:
  - Load: wb_sel=01, rd=8, memory stage returns 0xFFFFFF80 (LB of 0x80) → o_wb_data=0xFFFFFF80 in cycle t+1.
  - Link: wb_sel=10, pc8=0x40 with rd=31 → o_wb_data=0x40.
- $zero and bubble:
  - rd=0 with reg_write=1 → o_wb_we=0, o_retired increments.
  - i_valid=0 → o_wb_we=0, o_retired unchanged.
- Stall: capture rd=3/alu=7, then hold i_enable=0 for 3 cycles.
  - o_wb_we=0 and the counter does not change throughout.
  - After re-enable, exactly one write of 7 to r3 and count +1.
- Halt:
  - HALT followed by valid ALU write rd=9.
  - Result: o_halted=1 one edge after HALT is captured; r9 is never written; counter excludes both.
  - Then i_reset → o_halted=0, o_retired=0.
- Wrap: NB_CNT=4, retire 17 instructions → o_retired=1.
